// File: rtl/sender_mem_ctrl_pkg.sv
// sender_mem_ctrl_pkg: shared widths, burst limits and FSM state encoding for the sender memory scheduler
package sender_mem_ctrl_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int CNT_W = 5;
  localparam int MAX_BURST = 16;
  localparam int ACCESS_CYCLES = 3;
  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_WAIT, RD_CAP, WR_ISSUE, WR_WAIT, WR_DONE
  } state_t;
endpackage

// File: rtl/sender_tx_buffer.sv
// sender_tx_buffer: one-word TxData/TxValid holding register with valid/ready drain
module sender_tx_buffer #(
  parameter int DATA_W = sender_mem_ctrl_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  output logic              empty,
  output logic              xfer
);
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  // empty also covers a word leaving on this edge, so the next read can start without a bubble
  always_comb begin
    xfer    = valid_q && tx_ready;
    empty   = !valid_q || tx_ready;
    valid_d = load ? 1'b1 : (xfer ? 1'b0 : valid_q);
    data_d  = load ? load_data : data_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end
  assign tx_data  = data_q;
  assign tx_valid = valid_q;
endmodule

// File: rtl/sender_mem_ctrl.sv
// sender_mem_ctrl: schedules host writes and burst reads onto the 16x16 sender memory
module sender_mem_ctrl #(
  parameter int ADDR_W = sender_mem_ctrl_pkg::ADDR_W,
  parameter int DATA_W = sender_mem_ctrl_pkg::DATA_W,
  parameter int CNT_W  = sender_mem_ctrl_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              HostReq,
  input  logic [ADDR_W-1:0] HostAddr,
  input  logic [DATA_W-1:0] HostData,
  output logic              HostAck,
  input  logic              Send,
  input  logic [ADDR_W-1:0] StartAddr,
  input  logic [CNT_W-1:0]  Count,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] TxData,
  output logic              TxValid,
  input  logic              TxReady,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemDataIn,
  output logic              MemReadEnable,
  output logic              MemWriteEnable,
  input  logic [DATA_W-1:0] MemDataOut
);
  import sender_mem_ctrl_pkg::*;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d, maddr_q, maddr_d;
  logic [CNT_W-1:0]  rem_q, rem_d, cnt_clamped;
  logic [DATA_W-1:0] mdin_q, mdin_d;
  logic              busy_q, busy_d, done_q, done_d, ack_q, ack_d;
  logic              re_q, re_d, we_q, we_d;
  logic              load, tx_empty, tx_xfer, send_acc;
  sender_tx_buffer #(.DATA_W(DATA_W)) u_tx (
    .clk(clk), .rst(rst), .load(load), .load_data(MemDataOut), .tx_ready(TxReady),
    .tx_data(TxData), .tx_valid(TxValid), .empty(tx_empty), .xfer(tx_xfer)
  );
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    rem_d       = rem_q;
    maddr_d     = maddr_q;
    mdin_d      = mdin_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ack_d       = 1'b0;
    re_d        = re_q;
    we_d        = we_q;
    load        = 1'b0;
    send_acc    = Send && !busy_q;
    cnt_clamped = (Count > MAX_CNT) ? MAX_CNT : Count;
    if (send_acc) begin
      cur_addr_d = StartAddr;
      rem_d      = cnt_clamped;
      busy_d     = cnt_clamped != '0;
      done_d     = cnt_clamped == '0;
    end
    // remaining hits zero when the last word is loaded, so its transfer ends the burst
    if (busy_q && rem_q == '0 && tx_xfer) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (HostReq) begin
          state_d = WR_ISSUE;
          we_d    = 1'b1;
          maddr_d = HostAddr;
          mdin_d  = HostData;
        end else if (busy_q && rem_q != '0 && tx_empty) begin
          state_d = RD_ISSUE;
          re_d    = 1'b1;
          maddr_d = cur_addr_q;
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        state_d = RD_CAP;
        re_d    = 1'b0;
      end
      RD_CAP: begin
        state_d    = IDLE;
        load       = 1'b1;
        cur_addr_d = cur_addr_q + ADDR_W'(1);
        rem_d      = rem_q - CNT_W'(1);
      end
      WR_ISSUE: state_d = WR_WAIT;
      WR_WAIT: begin
        state_d = WR_DONE;
        we_d    = 1'b0;
        ack_d   = 1'b1;
      end
      WR_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      rem_q      <= '0;
      maddr_q    <= '0;
      mdin_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_q      <= 1'b0;
      re_q       <= 1'b0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
      maddr_q    <= maddr_d;
      mdin_q     <= mdin_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_q      <= ack_d;
      re_q       <= re_d;
      we_q       <= we_d;
    end
  end
  assign HostAck        = ack_q;
  assign Busy           = busy_q;
  assign Done           = done_q;
  assign MemAddr        = maddr_q;
  assign MemDataIn      = mdin_q;
  assign MemReadEnable  = re_q;
  assign MemWriteEnable = we_q;
endmodule

// File: doc/sender_mem_ctrl.md
Name: sender_mem_ctrl

Overview:
- Access scheduler for the 16x16 sender memory. Shares the memory between a host write port and a burst-read transmit engine.
- A Send command streams Count words from StartAddr onward out of a valid/ready Tx port.
- Host writes are arbitrated in between burst reads.
- Drives the memory's ReadEnable/WriteEnable/Address/DataIn with the fixed multi-cycle timing that memory needs.

Parameters:
ADDR_W, 4, memory address width (depth 2^ADDR_W)
DATA_W, 16, word width
CNT_W, 5, burst count width (ADDR_W+1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
HostReq  in  1  host write request; held high until HostAck
HostAddr  in  ADDR_W  host write address; stable while HostReq high
HostData  in  DATA_W  host write data; stable while HostReq high
HostAck  out  1  one-cycle pulse: host write completed
Send  in  1  start-burst pulse; sampled only when Busy=0
StartAddr  in  ADDR_W  first burst address, captured with Send
Count  in  CNT_W  words to send, captured with Send
Busy  out  1  burst in progress
Done  out  1  one-cycle pulse: burst finished
TxData  out  DATA_W  transmit word
TxValid  out  1  TxData valid
TxReady  in  1  consumer accepts TxData
MemAddr  out  ADDR_W  to memory Address
MemDataIn  out  DATA_W  to memory DataIn
MemReadEnable  out  1  to memory ReadEnable
MemWriteEnable  out  1  to memory WriteEnable
MemDataOut  in  DATA_W  from memory DataOut

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; burst registers cleared. Reset mid-operation aborts any access or burst: no Done, no HostAck, TxValid drops immediately.
- All outputs are registered.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, RD_CAP, WR_ISSUE, WR_WAIT, WR_DONE.
- Arbitration happens in IDLE only, in this priority order:
  - HostReq=1 -> WR_ISSUE.
  - Else if Busy=1, remaining>0 and TxValid=0 -> RD_ISSUE.
  - Else stay in IDLE.
- Read access (3 cycles):
  - RD_ISSUE and RD_WAIT: MemReadEnable=1, MemAddr=cur_addr.
  - RD_CAP: MemReadEnable=0, MemAddr held. At the end of RD_CAP: TxData<=MemDataOut, TxValid<=1, cur_addr<=cur_addr+1 (mod 2^ADDR_W), remaining<=remaining-1.
  - Then -> IDLE.
- Write access (3 cycles):
  - WR_ISSUE and WR_WAIT: MemWriteEnable=1, MemAddr=HostAddr, MemDataIn=HostData (registered at entry to WR_ISSUE).
  - WR_DONE: enables 0, address and data held, HostAck=1 for that cycle.
  - Then -> IDLE.
  - MemReadEnable and MemWriteEnable are never both 1.
- Tx handshake:
  - A word transfers on a rising edge where TxValid=1 and TxReady=1; TxValid clears the next cycle.
  - TxData is stable while TxValid=1 and TxReady=0.
  - Host writes may proceed while TxValid is held.
- Send:
  - Accepted when Busy=0 and Send=1: cur_addr<=StartAddr; remaining<=min(Count,16); Busy<=1 next cycle.
  - Send while Busy=1 is ignored.
  - Count=0: Busy stays 0 and Done pulses one cycle after Send.
- Done: pulses one cycle after the Tx transfer of the last word; Busy clears in the same cycle.
- Address wrap: StartAddr=14, Count=4 reads 14, 15, 0, 1.
- Hazard: a host write granted before a read of the same address is visible to that read.
- Throughput:
  - Minimum 4 cycles per word with TxReady tied high (RD_ISSUE, RD_WAIT, RD_CAP, IDLE).
  - A pending HostReq adds 4 cycles per interleaved write.

Decomposition:
- Shared package holds:
  - FSM state typedef (3 bits).
  - ADDR_W, DATA_W, CNT_W defaults.
  - Constant MAX_BURST=16.
  - Constant ACCESS_CYCLES=3.
- Natural sub-module: sender_tx_buffer. It is the one-word TxData/TxValid holding register with load and handshake-drain logic, and reports empty to the FSM.

Test Plan:
1. Reset mid-burst (assert rst during RD_WAIT of word 2) -> all outputs 0 immediately; no Done; next Send works normally.
2. Host writes 0xA000+i to address i for i=0..15, each HostAck seen exactly 3 cycles after its grant; then Send StartAddr=0, Count=16 with TxReady=1 -> TxData sequence 0xA000..0xA00F, Done once, 64 cycles Send-to-Done ±2.
3. Wrap: Send StartAddr=14, Count=4 -> MemAddr reads 14, 15, 0, 1; four Tx transfers; Done.
4. Backpressure: TxReady=0 for 20 cycles after first TxValid -> TxData stable, no further reads issued, MemReadEnable=0 throughout; release -> burst completes in order.
5. Contention: HostReq (addr 5, 0x1234) asserted during the burst's RD_ISSUE of addr 3, burst StartAddr=3, Count=4 -> write granted at the next IDLE, before the addr-4 read; addr 5 returns 0x1234; enables never overlap.
6. Edge commands: Count=0 -> Done 1 cycle later, no memory access; Count=31 -> exactly 16 words; Send while Busy -> ignored, word count unchanged.
